// File: rtl/divide_if.sv
// Request and writeback bundle for the iterative divider.
// master = issue/writeback side, slave = divider.
interface divide_if;
    logic [63:0] opr_a_i;
    logic [63:0] opr_b_i;
    logic        div_instr_i;
    logic [2:0]  div_func_i;
    logic [4:0]  rd_addr_i;
    logic        word_op_i;
    logic        stall_i;
    logic        kill_i;
    logic        busy_o;
    logic [63:0] div_res_o;
    logic        valid_res_o;
    logic [4:0]  rd_addr_o;
    logic        rd_wr_en_o;

    modport master (
        output opr_a_i, opr_b_i, div_instr_i, div_func_i, rd_addr_i,
               word_op_i, stall_i, kill_i,
        input  busy_o, div_res_o, valid_res_o, rd_addr_o, rd_wr_en_o
    );

    modport slave (
        input  opr_a_i, opr_b_i, div_instr_i, div_func_i, rd_addr_i,
               word_op_i, stall_i, kill_i,
        output busy_o, div_res_o, valid_res_o, rd_addr_o, rd_wr_en_o
    );
endinterface

// File: rtl/divide.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Optional DIV_EARLY_OUT_EN: finish at capture when |dividend| < |divisor|.
module divide (
    input  logic    clk,
    input  logic    reset,
    divide_if.slave div_if
);
    // state | meaning
    // IDLE  | waiting for a request
    // CALC  | one quotient bit per cycle
    // DONE  | result presented, held while stalled
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] rem_q, rem_d;
    logic [63:0] quo_q, quo_d;
    logic [63:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [2:0]  func_q, func_d;
    logic        word_q, word_d;
    logic [4:0]  rd_q, rd_d;
    logic [63:0] res_q, res_d;

    logic        sgn, sign_a, sign_b;
    logic [63:0] a_ext, b_ext, a_mag, b_mag, min_neg;
    logic        div_zero, ovf, spec_hit;
    logic [63:0] spec_res;
    logic [64:0] rem_sh, diff;
    logic [63:0] quo_sh, rem_nx, quo_nx, quo_fix, rem_fix;
    logic [5:0]  last_cnt;

    function automatic logic [63:0] pick_res(input logic [63:0] q, input logic [63:0] r,
                                             input logic [2:0] func, input logic word);
        logic [63:0] sel;
        case (func)
            3'b100, 3'b101: sel = q;
            3'b110, 3'b111: sel = r;
            default:        sel = 64'd0;
        endcase
        if (word) sel = {{32{sel[31]}}, sel[31:0]};
        return sel;
    endfunction

    always_comb begin
        sgn = (div_if.div_func_i == 3'b100) || (div_if.div_func_i == 3'b110);
        if (div_if.word_op_i) begin
            a_ext   = {{32{sgn & div_if.opr_a_i[31]}}, div_if.opr_a_i[31:0]};
            b_ext   = {{32{sgn & div_if.opr_b_i[31]}}, div_if.opr_b_i[31:0]};
            min_neg = 64'hFFFF_FFFF_8000_0000;
        end else begin
            a_ext   = div_if.opr_a_i;
            b_ext   = div_if.opr_b_i;
            min_neg = 64'h8000_0000_0000_0000;
        end
        sign_a   = sgn & a_ext[63];
        sign_b   = sgn & b_ext[63];
        a_mag    = sign_a ? (64'd0 - a_ext) : a_ext;
        b_mag    = sign_b ? (64'd0 - b_ext) : b_ext;
        div_zero = (b_ext == 64'd0);
        ovf      = sgn && (a_ext == min_neg) && (b_ext == 64'hFFFF_FFFF_FFFF_FFFF);

        spec_hit = 1'b0;
        spec_res = 64'd0;
        if (div_zero) begin
            spec_hit = 1'b1;
            spec_res = pick_res(64'hFFFF_FFFF_FFFF_FFFF, a_ext, div_if.div_func_i, div_if.word_op_i);
        end else if (ovf) begin
            spec_hit = 1'b1;
            spec_res = pick_res(a_ext, 64'd0, div_if.div_func_i, div_if.word_op_i);
        end
`ifdef DIV_EARLY_OUT_EN
        else if (a_mag < b_mag) begin
            spec_hit = 1'b1;
            spec_res = pick_res(64'd0, a_ext, div_if.div_func_i, div_if.word_op_i);
        end
`endif
    end

    // One restoring step; the borrow out of the 65-bit subtract is the compare result.
    always_comb begin
        rem_sh  = {rem_q, quo_q[63]};
        quo_sh  = {quo_q[62:0], 1'b0};
        diff    = rem_sh - {1'b0, dvs_q};
        if (!diff[64]) begin
            rem_nx = diff[63:0];
            quo_nx = quo_sh | 64'd1;
        end else begin
            rem_nx = rem_sh[63:0];
            quo_nx = quo_sh;
        end
        quo_fix  = neg_quo_q ? (64'd0 - quo_nx) : quo_nx;
        rem_fix  = neg_rem_q ? (64'd0 - rem_nx) : rem_nx;
        last_cnt = word_q ? 6'd31 : 6'd63;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        func_d    = func_q;
        word_d    = word_q;
        rd_d      = rd_q;
        res_d     = res_q;

        case (state_q)
            IDLE: begin
                if (div_if.div_instr_i) begin
                    cnt_d     = 6'd0;
                    rem_d     = 64'd0;
                    // Word dividends sit in the upper half so 32 shifts consume them.
                    quo_d     = div_if.word_op_i ? {a_mag[31:0], 32'd0} : a_mag;
                    dvs_d     = b_mag;
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    func_d    = div_if.div_func_i;
                    word_d    = div_if.word_op_i;
                    rd_d      = div_if.rd_addr_i;
                    if (spec_hit) begin
                        res_d   = spec_res;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == last_cnt) begin
                    res_d   = pick_res(quo_fix, rem_fix, func_q, word_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!div_if.stall_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (div_if.kill_i) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            rem_q     <= 64'd0;
            quo_q     <= 64'd0;
            dvs_q     <= 64'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            func_q    <= 3'd0;
            word_q    <= 1'b0;
            rd_q      <= 5'd0;
            res_q     <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            func_q    <= func_d;
            word_q    <= word_d;
            rd_q      <= rd_d;
            res_q     <= res_d;
        end
    end

    assign div_if.busy_o      = (state_q != IDLE);
    assign div_if.valid_res_o = (state_q == DONE);
    assign div_if.rd_wr_en_o  = (state_q == DONE);
    assign div_if.div_res_o   = res_q;
    assign div_if.rd_addr_o   = rd_q;
endmodule

// File: tb/tb_divide.sv
// Table-driven bench for divide with a result scoreboard; expectations are for the default build.
module tb_divide;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    divide_if dif();
    divide dut (.clk(clk), .reset(reset), .div_if(dif.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  func;
        logic        word;
        logic [4:0]  rd;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        int          id;
        logic [63:0] res;
        logic [4:0]  rd;
        int          lat;
        int          acc;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[$];

    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops on the first valid cycle, checks hold while stalled.
    bit          seen = 1'b0;
    bit          pulse_chk = 1'b0;
    logic [63:0] held_res;
    logic [4:0]  held_rd;
    sb_t         ent;

    always @(negedge clk) begin
        if (reset) begin
            seen      = 1'b0;
            pulse_chk = 1'b0;
        end else begin
            if (pulse_chk) check("valid_pulse", 64'(dif.valid_res_o), 64'd0);
            pulse_chk = 1'b0;
            if (dif.valid_res_o) begin
                check("wr_en", 64'(dif.rd_wr_en_o), 64'd1);
                if (!seen) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_valid: got result %h, required no result", dif.div_res_o);
                    end else begin
                        ent = sb.pop_front();
                        check($sformatf("res#%0d", ent.id), dif.div_res_o, ent.res);
                        check($sformatf("rd#%0d", ent.id), 64'(dif.rd_addr_o), 64'(ent.rd));
                        check($sformatf("lat#%0d", ent.id), 64'(cyc - ent.acc), 64'(ent.lat));
                    end
                    held_res = dif.div_res_o;
                    held_rd  = dif.rd_addr_o;
                    seen     = 1'b1;
                end else begin
                    check("hold_res", dif.div_res_o, held_res);
                    check("hold_rd", 64'(dif.rd_addr_o), 64'(held_rd));
                end
                if (!dif.stall_i || dif.kill_i) begin
                    seen      = 1'b0;
                    pulse_chk = 1'b1;
                end
            end
        end
    end

    // Caller is positioned just after a rising edge; the next edge is E0.
    task automatic issue(input vec_t v, input int id, input bit expect_res);
        sb_t e;
        dif.opr_a_i     = v.a;
        dif.opr_b_i     = v.b;
        dif.div_func_i  = v.func;
        dif.word_op_i   = v.word;
        dif.rd_addr_i   = v.rd;
        dif.div_instr_i = 1'b1;
        @(posedge clk);
        #1;
        dif.div_instr_i = 1'b0;
        if (expect_res) begin
            e.id  = id;
            e.res = v.exp;
            e.rd  = v.rd;
            e.lat = v.lat;
            e.acc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        check($sformatf("busy#%0d", id), 64'(dif.busy_o), 64'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((sb.size() != 0 || dif.busy_o) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", 64'(k < 300), 64'd1);
    endtask

    initial begin
        vec_t v;
        int   k;
        int   vcnt;
        sb_t  e;

        dif.opr_a_i     = '0;
        dif.opr_b_i     = '0;
        dif.div_instr_i = 1'b0;
        dif.div_func_i  = '0;
        dif.rd_addr_i   = '0;
        dif.word_op_i   = 1'b0;
        dif.stall_i     = 1'b0;
        dif.kill_i      = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(dif.busy_o), 64'd0);
        check("rst_valid", 64'(dif.valid_res_o), 64'd0);
        check("rst_wr_en", 64'(dif.rd_wr_en_o), 64'd0);
        check("rst_res", dif.div_res_o, 64'd0);
        check("rst_rd", 64'(dif.rd_addr_o), 64'd0);
        reset = 1'b0;

        //                a                       b                       func    w     rd     expected                lat
        vecs.push_back('{64'd100,                 64'hFFFF_FFFF_FFFF_FFF9, F_DIV,  1'b0, 5'd5,  64'hFFFF_FFFF_FFFF_FFF2, 64});
        vecs.push_back('{64'h0000_0000_FFFF_FFF9, 64'd2,                   F_REM,  1'b1, 5'd6,  64'hFFFF_FFFF_FFFF_FFFF, 32});
        vecs.push_back('{64'd5,                   64'd0,                   F_DIVU, 1'b0, 5'd7,  64'hFFFF_FFFF_FFFF_FFFF, 0});
        vecs.push_back('{64'd5,                   64'd0,                   F_REM,  1'b0, 5'd8,  64'd5,                   0});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, F_DIV,  1'b0, 5'd9,  64'h8000_0000_0000_0000, 0});
        vecs.push_back('{64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, F_REM,  1'b1, 5'd10, 64'd0,                   0});
        vecs.push_back('{64'd3,                   64'd10,                  F_DIVU, 1'b0, 5'd11, 64'd0,                   64});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   F_DIVU, 1'b0, 5'd12, 64'h7FFF_FFFF_FFFF_FFFF, 64});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   F_REMU, 1'b0, 5'd13, 64'd1,                   64});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, F_REMU, 1'b0, 5'd14, 64'h7FFF_FFFF_FFFF_FFFF, 64});
        vecs.push_back('{64'h0000_0000_FFFF_FFEC, 64'd3,                   F_DIV,  1'b1, 5'd15, 64'hFFFF_FFFF_FFFF_FFFA, 32});
        vecs.push_back('{64'h0000_0000_FFFF_FFFF, 64'd1,                   F_DIVU, 1'b1, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 32});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                   F_REM,  1'b0, 5'd17, 64'hFFFF_FFFF_FFFF_FFFE, 64});
        vecs.push_back('{64'd10,                  64'd3,                   3'b000, 1'b0, 5'd18, 64'd0,                   64});
        vecs.push_back('{64'h0000_0001_0000_0007, 64'd4,                   F_REMU, 1'b1, 5'd19, 64'd3,                   32});
        vecs.push_back('{64'h1234_5678_8000_0005, 64'd0,                   F_DIV,  1'b1, 5'd20, 64'hFFFF_FFFF_FFFF_FFFF, 0});
        vecs.push_back('{64'h0000_0000_8000_0005, 64'h0000_ABCD_0000_0000, F_REM,  1'b1, 5'd21, 64'hFFFF_FFFF_8000_0005, 0});
        vecs.push_back('{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, F_DIV,  1'b1, 5'd22, 64'hFFFF_FFFF_8000_0000, 0});
        vecs.push_back('{64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, F_DIV,  1'b0, 5'd23, 64'hFFFF_FFFF_FFFF_FFFD, 64});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'd3,                   F_REM,  1'b0, 5'd24, 64'hFFFF_FFFF_FFFF_FFFE, 64});

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            issue(vecs[i], i, 1'b1);
            wait_idle();
        end

        // Stall for three DONE cycles: valid must last four cycles with a held result.
        v = '{64'd100, 64'd7, F_DIVU, 1'b0, 5'd25, 64'd14, 64};
        @(posedge clk);
        #1;
        dif.stall_i = 1'b1;
        issue(v, 100, 1'b1);
        k = 0;
        while (!dif.valid_res_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("stall_valid_timeout", 64'(k < 200), 64'd1);
        vcnt = 1;
        repeat (2) begin
            @(negedge clk);
            if (dif.valid_res_o) vcnt++;
        end
        @(posedge clk);
        #1;
        dif.stall_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (dif.valid_res_o) vcnt++;
        end
        check("stall_len", 64'(vcnt), 64'd4);
        wait_idle();

        // Kill in the request cycle: nothing accepted.
        @(posedge clk);
        #1;
        dif.opr_a_i     = 64'd50;
        dif.opr_b_i     = 64'd5;
        dif.div_func_i  = F_DIVU;
        dif.word_op_i   = 1'b0;
        dif.div_instr_i = 1'b1;
        dif.kill_i      = 1'b1;
        @(posedge clk);
        #1;
        dif.div_instr_i = 1'b0;
        dif.kill_i      = 1'b0;
        @(negedge clk);
        check("kill_req_busy", 64'(dif.busy_o), 64'd0);

        // Kill around iteration 10, then a new request in the very next cycle.
        @(posedge clk);
        #1;
        issue('{64'd1000, 64'd3, F_DIVU, 1'b0, 5'd26, 64'd333, 64}, 200, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        dif.kill_i = 1'b1;
        @(posedge clk);
        #1;
        dif.kill_i      = 1'b0;
        dif.opr_a_i     = 64'd100;
        dif.opr_b_i     = 64'hFFFF_FFFF_FFFF_FFF9;
        dif.div_func_i  = F_DIV;
        dif.word_op_i   = 1'b0;
        dif.rd_addr_i   = 5'd3;
        dif.div_instr_i = 1'b1;
        @(negedge clk);
        check("kill_busy", 64'(dif.busy_o), 64'd0);
        check("kill_valid", 64'(dif.valid_res_o), 64'd0);
        @(posedge clk);
        #1;
        dif.div_instr_i = 1'b0;
        e.id  = 300;
        e.res = 64'hFFFF_FFFF_FFFF_FFF2;
        e.rd  = 5'd3;
        e.lat = 64;
        e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        check("post_kill_busy", 64'(dif.busy_o), 64'd1);
        wait_idle();

        // Asynchronous reset in the middle of CALC.
        @(posedge clk);
        #1;
        issue('{64'd77, 64'd5, F_DIVU, 1'b1, 5'd27, 64'd15, 32}, 400, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("areset_busy", 64'(dif.busy_o), 64'd0);
        check("areset_valid", 64'(dif.valid_res_o), 64'd0);
        check("areset_res", dif.div_res_o, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("after_reset_busy", 64'(dif.busy_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/divide.md
# divide

Iterative integer divider for the RV64M execute stage. It computes DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW with a radix-2 restoring algorithm, using one quotient bit per cycle. It sits beside the pipelined multiplier, and its writeback port (result, rd address, write enable, valid) has the same format. Because the unit is busy for multiple cycles, it exposes `busy_o` so the issue logic can hold further divide instructions.

## Interface
- No parameters.
- Ports:
  - `clk` input 1 — clock.
  - `reset` input 1 — asynchronous, active-high.
  - `opr_a_i` input 64 — dividend (rs1).
  - `opr_b_i` input 64 — divisor (rs2).
  - `div_instr_i` input 1 — request valid; sampled only in IDLE.
  - `div_func_i` input 3 — funct3 encoding: 100 DIV, 101 DIVU, 110 REM, 111 REMU. Any other value is accepted, and its result is 0.
  - `rd_addr_i` input 5 — destination register.
  - `word_op_i` input 1 — selects the W variant.
  - `stall_i` input 1 — writeback stall; holds a completed result.
  - `kill_i` input 1 — flush; aborts any operation in progress.
  - `busy_o` output 1 — high whenever state is not IDLE.
  - `div_res_o` output 64 — result.
  - `valid_res_o` output 1 — result valid.
  - `rd_addr_o` output 5 — destination register of the result.
  - `rd_wr_en_o` output 1 — register write enable; equals `valid_res_o`.

## Operation
- States:
  - IDLE: waits for a request.
  - CALC: iterates one quotient bit per cycle.
  - DONE: presents the result.
- Transitions:
  - IDLE with `div_instr_i && !kill_i`: captures the request and goes to CALC, or directly to DONE for a special case.
  - CALC with counter == N-1: goes to DONE.
  - DONE with `!stall_i`: goes to IDLE.
  - `kill_i` in any state: goes to IDLE, takes priority over every other condition, and discards the result.
- Signed ops are DIV and REM.
- Operand preparation:
  - Word ops take the low 32 bits of each operand, sign-extended for signed ops and zero-extended otherwise.
  - Both operands are converted to magnitude.
  - The capture stage records `neg_q = sign_a ^ sign_b` and `neg_r = sign_a`.
- Iteration width: N = 64, or N = 32 for word ops.
- Each CALC cycle performs `{rem,quo} <<= 1`. If `rem >= divisor` then `rem -= divisor` and the quotient LSB is set to 1.
- Final fix-up:
  - The quotient is negated if `neg_q`; the remainder is negated if `neg_r`.
  - The REM ops select the remainder, the DIV ops select the quotient.
  - Word ops sign-extend bit 31 of the selected value to 64 bits. This applies to DIVUW and REMUW as well.
- Special cases are resolved at capture and skip CALC:
  - Divisor == 0: quotient is all ones (for word ops, sign-extended 0xFFFFFFFF); remainder equals the dividend, sign-extended to 64 bits for word ops.
  - Signed overflow (dividend is the most negative value, divisor is -1): quotient equals the dividend, remainder is 0. The word form gives 0xFFFFFFFF80000000.
- `rd_addr_o` takes its value from the captured `rd_addr_i`.

## Timing
- Reset values:
  - State is IDLE.
  - `busy_o`, `valid_res_o`, `rd_wr_en_o` are 0.
  - `div_res_o` is 0 and `rd_addr_o` is 0.
  - The counter is 0.
- Define E0 as the clock edge that accepts a request.
- Normal latency: CALC occupies edges E0+1 through E0+N. `valid_res_o` is high in the cycle after edge E0+N, so a 64-bit op produces its result 65 cycles after acceptance and a word op 33 cycles after.
- Special-case latency: `valid_res_o` is high in the cycle after E0.
- `valid_res_o` stays high for exactly one cycle unless `stall_i` is high. While `stall_i` is high in DONE, `valid_res_o`, `div_res_o` and `rd_addr_o` hold their values.
- `busy_o` is high from the cycle after E0 until the cycle after the edge where DONE exits. A request presented while `busy_o` is high is ignored; the issue logic must hold it.
- Back-to-back requests: the next request can be accepted in the first IDLE cycle after DONE.
- Kill timing:
  - `kill_i` asserted in the cycle of a request means the request is not accepted.
  - `kill_i` during CALC or DONE returns the unit to IDLE on the next edge; `valid_res_o` is low from that edge on.
- An asynchronous reset during an operation returns the unit to the reset state immediately.
- `stall_i` has no effect in IDLE or CALC.

## Configuration
- Macro: `DIV_EARLY_OUT_EN`.
- When defined: at capture, an unsigned-magnitude dividend smaller than the divisor magnitude is treated as a special case. The result is quotient 0 and remainder equal to the dividend, sign-extended for word ops. `valid_res_o` is high in the cycle after E0.
- When not defined: such operands go through all N iterations and produce the identical result with normal latency.

## Test plan
- DIV with a = 100, b = -7 → result 0xFFFFFFFFFFFFFFF2 (-14); `valid_res_o` high in cycle E0+65; `rd_addr_o` equals the captured rd.
- REMW with a = 0x00000000_FFFFFFF9 (-7), b = 2 → result 0xFFFFFFFFFFFFFFFF (-1); valid in cycle E0+33.
- DIVU with b = 0 and a = 5 → result 0xFFFFFFFFFFFFFFFF. REM with b = 0 and a = 5 → result 5. Both valid in cycle E0+1.
- DIV with a = 0x8000000000000000, b = -1 → result 0x8000000000000000. REMW with a = 0x80000000, b = -1 → result 0. Both valid in cycle E0+1.
- DIVU with a = 3, b = 10 → result 0. Valid at E0+1 with `DIV_EARLY_OUT_EN` defined, at E0+65 without it.
- Flow control:
  - `stall_i` held for 3 cycles in DONE → `valid_res_o` stays high for 4 cycles with a constant result.
  - `kill_i` pulsed at CALC iteration 10 → no valid output, `busy_o` low on the next cycle, and a new request is accepted immediately afterwards.
